// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment driver.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package seg_scan_driver_pkg;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_state_t;

    typedef struct packed {
        logic       tens;
        logic [3:0] ones;
    } bcd_t;

    // Active-low segment patterns, bit order g..a.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low digit enables; AN_OFF darkens both digits.
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    // Input never exceeds 15, so a single compare-and-subtract is a full split.
    function automatic bcd_t bcd_split(input logic [3:0] v);
        bcd_t r;
        r.tens = (v >= 4'd10);
        r.ones = r.tens ? (v - 4'd10) : v;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_seg7_encode.sv
// Digit to active-low seven-segment pattern; codes 10..15 give a dark digit.
// Latency: combinational.
// Backpressure: none.
module seg7_encode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans a latched 0..15 count onto two multiplexed digits and flags 0->15 wraps.
// Latency: seg/an follow the digit slot by 1 clk; wrap/frame are 1-clk registered pulses.
// Backpressure: none; count is sampled every clk and the display latch reloads once per frame.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap,
    output logic       frame
);

    localparam int            RW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RTERM = RW'(REFRESH_DIV - 1);

    logic [RW-1:0] rcnt_q;
    logic          slot_end;
    dig_state_t    state_q;
    dig_state_t    state_d;
    logic          frame_load;
    logic [3:0]    disp_q;
    logic [3:0]    cnt_q;
    bcd_t          bcd;
    logic [3:0]    dig_sel;
    logic [6:0]    enc_seg;
    logic [6:0]    seg_d;
    logic [1:0]    an_d;

    assign slot_end = (rcnt_q == RTERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
        end else if (slot_end) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIG_ONES;
        end else begin
            state_q <= state_d;
        end
    end

    // The end of the tens slot closes a frame and is the only point the latch reloads.
    always_comb begin
        state_d    = state_q;
        frame_load = 1'b0;
        case (state_q)
            DIG_ONES: begin
                if (slot_end) begin
                    state_d = DIG_TENS;
                end
            end
            DIG_TENS: begin
                if (slot_end) begin
                    state_d    = DIG_ONES;
                    frame_load = 1'b1;
                end
            end
        endcase
    end

    assign bcd = bcd_split(disp_q);

    always_comb begin
        dig_sel = bcd.ones;
        an_d    = AN_ONES;
        seg_d   = enc_seg;
        if (state_q == DIG_TENS) begin
            dig_sel = {3'b000, bcd.tens};
            an_d    = AN_TENS;
            if (LZ_BLANK && !bcd.tens) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        end
    end

    seg7_encode u_enc (
        .digit (dig_sel),
        .seg   (enc_seg)
    );

    // cnt_q resets to 15 so a counter leaving reset at 15 never looks like 0->15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= 4'd0;
            cnt_q  <= 4'hF;
            seg    <= SEG_0;
            an     <= AN_ONES;
            wrap   <= 1'b0;
            frame  <= 1'b0;
        end else begin
            if (frame_load) begin
                disp_q <= count;
            end
            cnt_q <= count;
            seg   <= seg_d;
            an    <= an_d;
            wrap  <= (cnt_q == 4'd0) && (count == 4'hF);
            frame <= frame_load;
        end
    end

endmodule
